fetch_unit: RTL and testbench

//  Instruction-fetch stage: owns the program counter and drives inst_mem.address.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_buffer.sv | 54 +++++
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned N        = 32;
  localparam int unsigned PC_STEP  = 4;
  localparam logic [N-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [N-1:0] pc;
    logic [N-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Circular FIFO of fetched {pc, instr} entries with push/pop/flush.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_entry,
  output fetch_entry_t o_head,
  output logic         o_valid,
  output logic         o_full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Storage needs no reset: outputs are qualified by the count.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_tail] <= i_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PTR_W'(1);
      if (i_pop)  r_head <= r_head + PTR_W'(1);
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, next-PC selection, misalign flag and decode handoff.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned  n        = 32,
  parameter logic [n-1:0] RESET_PC = n'(DEFAULT_RESET_PC),
  parameter int unsigned  DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset,
  output logic [n-1:0] address,
  input  logic [n-1:0] instruction,
  input  logic         redirect_valid,
  input  logic [n-1:0] redirect_target,
  input  logic         dec_ready,
  output logic         dec_valid,
  output logic [n-1:0] dec_instr,
  output logic [n-1:0] dec_pc,
  output logic [n-1:0] dec_pc_plus4,
  output logic         misalign
);

  logic [n-1:0] r_pc;
  logic         r_misalign;
  logic [n-1:0] w_pc_next;
  logic         w_deq;
  logic         w_enq;
  logic         w_full;
  logic         w_valid;
  fetch_entry_t w_entry;
  fetch_entry_t w_head;

  assign w_deq = w_valid & dec_ready;
  assign w_enq = ~redirect_valid & (~w_full | w_deq);

  // Redirect beats sequential fetch; a stall holds the PC.
  always_comb begin
    w_pc_next = r_pc;
    if (redirect_valid) begin
      w_pc_next = {redirect_target[n-1:2], 2'b00};
    end else if (w_enq) begin
      w_pc_next = r_pc + n'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (redirect_valid) begin
        r_misalign <= r_misalign | (|redirect_target[1:0]);
      end
    end
  end

  assign w_entry.pc    = r_pc;
  assign w_entry.instr = instruction;

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_enq),
    .i_pop   (w_deq),
    .i_flush (redirect_valid),
    .i_entry (w_entry),
    .o_head  (w_head),
    .o_valid (w_valid),
    .o_full  (w_full)
  );

  // Decode fields are zero whenever the buffer is empty.
  assign address      = r_pc;
  assign misalign     = r_misalign;
  assign dec_valid    = w_valid;
  assign dec_pc       = w_valid ? w_head.pc : '0;
  assign dec_instr    = w_valid ? w_head.instr : '0;
  assign dec_pc_plus4 = w_valid ? (w_head.pc + n'(PC_STEP)) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and random checks of fetch_unit against a queue-based reference model.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] IMG_XOR = 32'hA5A5_0000;
  localparam logic [31:0] RPC2    = 32'hFFFF_FFF8;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        dec_ready;

  logic [31:0] address, instruction, dec_instr, dec_pc, dec_pc_plus4;
  logic        dec_valid, misalign;
  logic [31:0] address2, instruction2, dec_instr2, dec_pc2, dec_pc_plus42;
  logic        dec_valid2, misalign2;

  assign instruction  = address ^ IMG_XOR;
  assign instruction2 = address2 ^ IMG_XOR;

  fetch_unit #(.n(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .address(address), .instruction(instruction),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .dec_ready(dec_ready), .dec_valid(dec_valid), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .dec_pc_plus4(dec_pc_plus4), .misalign(misalign)
  );

  fetch_unit #(.n(32), .RESET_PC(RPC2), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .reset(reset), .address(address2), .instruction(instruction2),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .dec_ready(dec_ready), .dec_valid(dec_valid2), .dec_instr(dec_instr2),
    .dec_pc(dec_pc2), .dec_pc_plus4(dec_pc_plus42), .misalign(misalign2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  logic        m_mis;
  bit          known;
  int          checks;
  int          failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    logic [31:0] epc;
    logic [31:0] ein;
    epc = (q.size() != 0) ? q[0].pc : 32'h0;
    ein = (q.size() != 0) ? q[0].instr : 32'h0;
    chk("m_address", address, m_pc);
    chk("m_dec_valid", 32'(dec_valid), 32'(q.size() != 0));
    chk("m_dec_pc", dec_pc, epc);
    chk("m_dec_instr", dec_instr, ein);
    chk("m_dec_pc_plus4", dec_pc_plus4, (q.size() != 0) ? epc + 32'd4 : 32'h0);
    chk("m_misalign", 32'(misalign), 32'(m_mis));
  endtask

  // Reference behaviour: what one clock edge does, in terms of the fetch queue.
  task automatic model_edge(input logic rst, input logic rdy, input logic rv, input logic [31:0] tgt);
    int  sz;
    bit  deq;
    if (rst) begin
      q.delete();
      m_pc  = 32'h0;
      m_mis = 1'b0;
      known = 1'b1;
    end else if (known) begin
      if (rv) begin
        q.delete();
        m_pc  = tgt & 32'hFFFF_FFFC;
        m_mis = m_mis | (tgt[1:0] != 2'b00);
      end else begin
        sz  = q.size();
        deq = (sz != 0) && rdy;
        if (sz < DEPTH || deq) begin
          q.push_back('{pc: m_pc, instr: m_pc ^ IMG_XOR});
          m_pc = m_pc + 32'd4;
        end
        if (deq) void'(q.pop_front());
      end
    end
  endtask

  // Drive one cycle from a negedge: check outputs, clock, advance the model.
  task automatic cycle(input logic rst, input logic rdy, input logic rv, input logic [31:0] tgt);
    reset = rst; dec_ready = rdy; redirect_valid = rv; redirect_target = tgt;
    #1;
    if (known) compare_model();
    @(posedge clk);
    model_edge(rst, rdy, rv, tgt);
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0; known = 1'b0;
    q.delete(); m_pc = 32'h0; m_mis = 1'b0;
    reset = 1'b1; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    @(negedge clk);

    // Reset, then free-running fetch with decode always ready.
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rst_address", address, 32'h0);
    chk("rst_dec_valid", 32'(dec_valid), 32'h0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_dec_instr", dec_instr, 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);
    chk("rst2_address", address2, RPC2);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("run_dec_pc", dec_pc, 32'(4 * i));
      chk("run_dec_instr", dec_instr, 32'(4 * i) ^ IMG_XOR);
      chk("run_address", address, 32'(4 * (i + 1)));
      chk("wrap_dec_pc", dec_pc2, RPC2 + 32'(4 * i));
      chk("wrap_dec_pc_plus4", dec_pc_plus42, RPC2 + 32'(4 * i + 4));
    end

    // Stall until full, then release: no gap, drop or duplicate.
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("stall_address", address, 32'h8);
    chk("stall_dec_pc", dec_pc, 32'h0);
    chk("stall_dec_valid", 32'(dec_valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk("release_dec_pc", dec_pc, 32'(4 * i));
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
    end

    // Redirect with a full buffer flushes it.
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 32'h100);
    chk("redir_dec_valid", 32'(dec_valid), 32'h0);
    chk("redir_address", address, 32'h100);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("redir_tgt_valid", 32'(dec_valid), 32'h1);
    chk("redir_tgt_pc", dec_pc, 32'h100);
    chk("redir_tgt_plus4", dec_pc_plus4, 32'h104);

    // Misaligned target sets the sticky flag.
    cycle(1'b0, 1'b1, 1'b1, 32'h102);
    chk("mis_address", address, 32'h100);
    chk("mis_flag", 32'(misalign), 32'h1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("mis_sticky", 32'(misalign), 32'h1);

    // Reset while stalled and full.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("full_pre_rst_valid", 32'(dec_valid), 32'h1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("midrst_dec_valid", 32'(dec_valid), 32'h0);
    chk("midrst_address", address, 32'h0);
    chk("midrst_misalign", 32'(misalign), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 60) == 0, ($urandom % 4) != 0,
            ($urandom % 8) == 0, $urandom);
    end
    cycle(1'b0, 1'b1, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
